// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory: latch one request,
// drive the memory strobes for one cycle, return a registered completion. Macro DMEM_ARB_RR_EN enables round-robin ties.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [DM_ADDRESS-1:0] m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [2:0]            m0_funct3,
  output logic                  m0_gnt,
  output logic                  m0_done,
  output logic                  m0_err,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [DM_ADDRESS-1:0] m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [2:0]            m1_funct3,
  output logic                  m1_gnt,
  output logic                  m1_done,
  output logic                  m1_err,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  output logic [2:0]            Funct3,
  input  logic [DATA_W-1:0]     rd
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] lsb);
    logic ok;
    case (f3[1:0])
      2'b10:   ok = (lsb == 2'b00);
      2'b01:   ok = (lsb[0] == 1'b0);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  owner_q, owner_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
`ifdef DMEM_ARB_RR_EN
  logic                  favour_m1_q, favour_m1_d;
`endif

  logic                  sel_m1_s;
  logic                  sel_we_s;
  logic [DM_ADDRESS-1:0] sel_addr_s;
  logic [DATA_W-1:0]     sel_wdata_s;
  logic [2:0]            sel_funct3_s;
  logic                  gnt0_s, gnt1_s;
  logic                  access_s, resp_s;

  // Winner selection and mux of the winning request fields
  always_comb begin
`ifdef DMEM_ARB_RR_EN
    sel_m1_s = m1_req & (~m0_req | favour_m1_q);
`else
    sel_m1_s = m1_req & ~m0_req;
`endif
    if (sel_m1_s) begin
      sel_we_s     = m1_we;
      sel_addr_s   = m1_addr;
      sel_wdata_s  = m1_wdata;
      sel_funct3_s = m1_funct3;
    end else begin
      sel_we_s     = m0_we;
      sel_addr_s   = m0_addr;
      sel_wdata_s  = m0_wdata;
      sel_funct3_s = m0_funct3;
    end
  end

  // Next-state logic; grants are suppressed while reset is applied
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    owner_d  = owner_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    gnt0_s   = 1'b0;
    gnt1_s   = 1'b0;
`ifdef DMEM_ARB_RR_EN
    favour_m1_d = favour_m1_q;
`endif
    case (state_q)
      IDLE: begin
        if ((m0_req || m1_req) && !reset) begin
          gnt0_s   = ~sel_m1_s;
          gnt1_s   = sel_m1_s;
          we_d     = sel_we_s;
          addr_d   = sel_addr_s;
          wdata_d  = sel_wdata_s;
          funct3_d = sel_funct3_s;
          owner_d  = sel_m1_s;
          err_d    = ~is_aligned(sel_funct3_s, sel_addr_s[1:0]);
          rdata_d  = '0;
          // Misaligned requests still spend the ACCESS slot (strobes masked) to keep latency uniform
          state_d  = ACCESS;
`ifdef DMEM_ARB_RR_EN
          favour_m1_d = ~sel_m1_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        rdata_d = (we_q || err_q) ? '0 : rd;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and transaction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= 3'b000;
      owner_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
`ifdef DMEM_ARB_RR_EN
      favour_m1_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      owner_q  <= owner_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
`ifdef DMEM_ARB_RR_EN
      favour_m1_q <= favour_m1_d;
`endif
    end
  end

  assign access_s = (state_q == ACCESS) && !err_q;
  assign resp_s   = (state_q == RESP);

  assign MemRead  = access_s & ~we_q;
  assign MemWrite = access_s & we_q;
  assign a        = access_s ? addr_q   : '0;
  assign wd       = access_s ? wdata_q  : '0;
  assign Funct3   = access_s ? funct3_q : 3'b000;

  assign m0_gnt   = gnt0_s;
  assign m1_gnt   = gnt1_s;
  assign m0_done  = resp_s & ~owner_q;
  assign m1_done  = resp_s & owner_q;
  assign m0_err   = resp_s & ~owner_q & err_q;
  assign m1_err   = resp_s & owner_q & err_q;
  assign m0_rdata = (resp_s && !owner_q) ? rdata_q : '0;
  assign m1_rdata = (resp_s && owner_q)  ? rdata_q : '0;

endmodule
